// File: rtl/os_sched.sv
`default_nettype none
// ============================================================================
// Module   : os_sched
// Purpose  : Frame scheduler for the overlap-save frequency-domain path.
//            Tracks frames launched into the FFT by os_buffer, throttles the
//            upstream sample source when MAXF frames are in flight, and on
//            the IFFT output drops the first N (aliased) samples of each 2N
//            frame while forwarding the last N bit-exact.
// Ports    : i_clk, i_rst (async, active-high)
//            i_fft_start / i_fft_valid     - os_buffer frame start / sample valid
//            i_ifft_valid, i_ifft_yI/yQ    - IFFT output stream (natural order)
//            o_src_en                      - upstream may present samples
//            o_y_valid, o_yI/o_yQ          - kept output samples
//            o_frame_done                  - pulse with last kept sample
//            o_inflight                    - frames launched, not completed
//            o_frame_cnt                   - completed frames (wrapping)
//            o_err                         - sticky protocol error
// Option   : OS_SCHED_ERR_EN - enables the input tracker and the sticky
//            protocol error; when undefined o_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module os_sched #(
  parameter int N    = 16,
  parameter int WN   = 9,
  parameter int MAXF = 2,
  parameter int FCW  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fft_start,
  input  logic                       i_fft_valid,
  input  logic                       i_ifft_valid,
  input  logic [WN-1:0]              i_ifft_yI,
  input  logic [WN-1:0]              i_ifft_yQ,
  output logic                       o_src_en,
  output logic                       o_y_valid,
  output logic [WN-1:0]              o_yI,
  output logic [WN-1:0]              o_yQ,
  output logic                       o_frame_done,
  output logic [$clog2(MAXF+1)-1:0]  o_inflight,
  output logic [FCW-1:0]             o_frame_cnt,
  output logic                       o_err
);

  localparam int IW = $clog2(MAXF + 1);
  localparam int XW = $clog2(2 * N);
  localparam logic [IW-1:0] MAXF_C   = IW'(MAXF);
  localparam logic [XW-1:0] HALF_IDX = XW'(N - 1);
  localparam logic [XW-1:0] LAST_IDX = XW'(2 * N - 1);

  typedef enum logic [0:0] {
    S_DISCARD = 1'b0,
    S_KEEP    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   oidx_q, oidx_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic            y_valid_q, y_valid_d;
  logic [WN-1:0]   yi_q, yi_d;
  logic [WN-1:0]   yq_q, yq_d;
  logic            frame_done_q, frame_done_d;
  logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;

  logic accept;
  logic frame_last;
  logic overflow;
  logic inc;

  // A sample only belongs to a frame if one is in flight, or one is being
  // launched in this very cycle.
  assign accept     = i_ifft_valid && ((inflight_q != '0) || i_fft_start);
  assign frame_last = accept && (state_q == S_KEEP) && (oidx_q == LAST_IDX);
  assign overflow   = i_fft_start && (inflight_q == MAXF_C) && !frame_last;
  assign inc        = i_fft_start && !overflow;

  always_comb begin
    state_d      = state_q;
    oidx_d       = oidx_q;
    inflight_d   = inflight_q;
    y_valid_d    = 1'b0;
    yi_d         = yi_q;
    yq_d         = yq_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // Credit counter: a start and a completion in the same cycle cancel.
    case ({inc, frame_last})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (accept) begin
      case (state_q)
        S_DISCARD: begin
          oidx_d = oidx_q + XW'(1);
          if (oidx_q == HALF_IDX) begin
            state_d = S_KEEP;
          end
        end
        S_KEEP: begin
          y_valid_d = 1'b1;
          yi_d      = i_ifft_yI;
          yq_d      = i_ifft_yQ;
          if (oidx_q == LAST_IDX) begin
            oidx_d       = '0;
            state_d      = S_DISCARD;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FCW'(1);
          end else begin
            oidx_d = oidx_q + XW'(1);
          end
        end
        default: begin
          state_d = S_DISCARD;
          oidx_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_DISCARD;
      oidx_q       <= '0;
      inflight_q   <= '0;
      y_valid_q    <= 1'b0;
      yi_q         <= '0;
      yq_q         <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      oidx_q       <= oidx_d;
      inflight_q   <= inflight_d;
      y_valid_q    <= y_valid_d;
      yi_q         <= yi_d;
      yq_q         <= yq_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

`ifdef OS_SCHED_ERR_EN
  // Input-side tracker: counts os_buffer valids within a frame so a start
  // arriving before 2N valids (short frame) can be flagged.
  logic [XW-1:0] iidx_q, iidx_d;
  logic          err_q, err_d;

  always_comb begin
    iidx_d = iidx_q;
    if (i_fft_start) begin
      // A valid coinciding with the start is the first sample of the frame.
      iidx_d = i_fft_valid ? XW'(1) : '0;
    end else if (i_fft_valid) begin
      iidx_d = (iidx_q == LAST_IDX) ? '0 : iidx_q + XW'(1);
    end

    err_d = err_q
          | overflow
          | (i_fft_start && (iidx_q != '0))
          | (i_ifft_valid && !accept);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      iidx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      iidx_q <= iidx_d;
      err_q  <= err_d;
    end
  end

  assign o_err = err_q;
`else
  // Without error checking the input valid has no consumer.
  logic unused_fft_valid;
  assign unused_fft_valid = i_fft_valid;
  assign o_err            = 1'b0;
`endif

  assign o_src_en     = (inflight_q < MAXF_C);
  assign o_y_valid    = y_valid_q;
  assign o_yI         = yi_q;
  assign o_yQ         = yq_q;
  assign o_frame_done = frame_done_q;
  assign o_inflight   = inflight_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_os_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_sched
// Purpose  : Self-checking bench for os_sched (N=16, WN=9, MAXF=2, FCW=16).
//            Table-driven vectors for two complete frames (contiguous and
//            gapped IFFT output), then directed sequences for drops,
//            credit saturation, start/complete collision and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_os_sched;

  localparam int N    = 16;
  localparam int WN   = 9;
  localparam int MAXF = 2;
  localparam int FCW  = 16;

`ifdef OS_SCHED_ERR_EN
  localparam logic ERRV = 1'b1;
`else
  localparam logic ERRV = 1'b0;
`endif

  logic          clk, rst;
  logic          fft_start, fft_valid, ifft_valid;
  logic [WN-1:0] ifft_yi, ifft_yq;
  logic          src_en, y_valid, frame_done, err;
  logic [WN-1:0] yi, yq;
  logic [1:0]    inflight;
  logic [FCW-1:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  os_sched #(.N(N), .WN(WN), .MAXF(MAXF), .FCW(FCW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fft_start  (fft_start),
    .i_fft_valid  (fft_valid),
    .i_ifft_valid (ifft_valid),
    .i_ifft_yI    (ifft_yi),
    .i_ifft_yQ    (ifft_yq),
    .o_src_en     (src_en),
    .o_y_valid    (y_valid),
    .o_yI         (yi),
    .o_yQ         (yq),
    .o_frame_done (frame_done),
    .o_inflight   (inflight),
    .o_frame_cnt  (frame_cnt),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start, fv, iv;
    logic [WN-1:0] in_i, in_q;
    logic          e_src, e_yv;
    logic [WN-1:0] e_yi, e_yq;
    logic          e_fd;
    logic [1:0]    e_inf;
    logic [FCW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic f, logic v, logic [WN-1:0] ii,
                              logic [WN-1:0] iq, logic esrc, logic eyv,
                              logic [WN-1:0] eyi, logic [WN-1:0] eyq,
                              logic efd, logic [1:0] einf, logic [FCW-1:0] ecnt);
    vec_t r;
    r.start = s;  r.fv = f;  r.iv = v;  r.in_i = ii;  r.in_q = iq;
    r.e_src = esrc; r.e_yv = eyv; r.e_yi = eyi; r.e_yq = eyq;
    r.e_fd = efd; r.e_inf = einf; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic s, input logic f, input logic v,
                      input logic [WN-1:0] ii, input logic [WN-1:0] iq);
    @(negedge clk);
    fft_start  = s;
    fft_valid  = f;
    ifft_valid = v;
    ifft_yi    = ii;
    ifft_yq    = iq;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src_en"},     int'(src_en),     1);
    chk({tag, "_y_valid"},    int'(y_valid),    0);
    chk({tag, "_yI"},         int'(yi),         0);
    chk({tag, "_yQ"},         int'(yq),         0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_inflight"},   int'(inflight),   0);
    chk({tag, "_frame_cnt"},  int'(frame_cnt),  0);
    chk({tag, "_err"},        int'(err),        0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fft_start = 1'b0; fft_valid = 1'b0; ifft_valid = 1'b0;
    ifft_yi = '0; ifft_yq = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Feed one 2N-sample IFFT frame, values k / k+200; optionally raise a new
  // start together with the final sample.
  task automatic run_frame(input string tag, input logic start_last,
                           input logic [1:0] inf_end, input logic src_end,
                           input int cnt_end, input logic err_exp);
    for (int k = 0; k < 2 * N; k++) begin
      step(start_last && (k == 2 * N - 1), 1'b0, 1'b1, WN'(k), WN'(k + 200));
      chk({tag, "_y_valid"}, int'(y_valid), (k >= N) ? 1 : 0);
      chk({tag, "_frame_done"}, int'(frame_done), (k == 2 * N - 1) ? 1 : 0);
      if (k >= N) begin
        chk({tag, "_yI"}, int'(yi), k);
        chk({tag, "_yQ"}, int'(yq), k + 200);
      end
    end
    chk({tag, "_inflight_end"}, int'(inflight), int'(inf_end));
    chk({tag, "_src_en_end"},   int'(src_en),   int'(src_end));
    chk({tag, "_cnt_end"},      int'(frame_cnt), cnt_end);
    chk({tag, "_err_end"},      int'(err),      int'(err_exp));
  endtask

  initial begin
    rst = 1'b1;
    fft_start = 1'b0; fft_valid = 1'b0; ifft_valid = 1'b0;
    ifft_yi = '0; ifft_yq = '0;

    // ---------------- vector table ----------------
    tbl.push_back(mk(0,0,0, 0,0, 1,0, 0,0, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 0,0, 1,0, 0,0, 0, 1, 0));
    for (int j = 0; j < 2 * N; j++)
      tbl.push_back(mk(0,1,0, 0,0, 1,0, 0,0, 0, 1, 0));
    // Frame 1: contiguous, yI=k, yQ=k+100.
    for (int k = 0; k < 2 * N; k++)
      tbl.push_back(mk(0,0,1, WN'(k), WN'(k + 100), 1, (k >= N),
                       (k >= N) ? WN'(k) : WN'(0),
                       (k >= N) ? WN'(k + 100) : WN'(0),
                       (k == 2 * N - 1),
                       (k == 2 * N - 1) ? 2'd0 : 2'd1,
                       (k == 2 * N - 1) ? FCW'(1) : FCW'(0)));
    tbl.push_back(mk(0,0,0, 0,0, 1,0, WN'(31),WN'(131), 0, 0, 1));
    tbl.push_back(mk(1,0,0, 0,0, 1,0, WN'(31),WN'(131), 0, 1, 1));
    // Frame 2: valid toggles 1/0; gap cycles carry junk data that must be ignored.
    for (int j = 0; j < 4 * N; j++) begin
      automatic int   k = j / 2;
      automatic logic v = ((j % 2) == 0);
      tbl.push_back(mk(0,0,v,
                       v ? WN'(k) : WN'(9'h1AA),
                       v ? WN'(k + 300) : WN'(9'h055),
                       1, v && (k >= N),
                       (k >= N) ? WN'(k) : WN'(31),
                       (k >= N) ? WN'(k + 300) : WN'(131),
                       v && (k == 2 * N - 1),
                       (j >= 4 * N - 2) ? 2'd0 : 2'd1,
                       (j >= 4 * N - 2) ? FCW'(2) : FCW'(1)));
    end

    // Reset is asserted from time 0 and released on a falling edge.
    @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].fv, tbl[i].iv, tbl[i].in_i, tbl[i].in_q);
      if ((src_en !== tbl[i].e_src) || (y_valid !== tbl[i].e_yv) ||
          (yi !== tbl[i].e_yi) || (yq !== tbl[i].e_yq) ||
          (frame_done !== tbl[i].e_fd) || (inflight !== tbl[i].e_inf) ||
          (frame_cnt !== tbl[i].e_cnt) || (err !== 1'b0)) begin
        n_fail++;
        $display("FAIL vec%0d: got src=%0b yv=%0b yI=%0d yQ=%0d fd=%0b inf=%0d cnt=%0d err=%0b, expected src=%0b yv=%0b yI=%0d yQ=%0d fd=%0b inf=%0d cnt=%0d err=0",
                 i, src_en, y_valid, yi, yq, frame_done, inflight, frame_cnt, err,
                 tbl[i].e_src, tbl[i].e_yv, tbl[i].e_yi, tbl[i].e_yq,
                 tbl[i].e_fd, tbl[i].e_inf, tbl[i].e_cnt);
      end
      n_tests++;
    end

    // ---------------- dropped IFFT sample with nothing in flight ----------------
    step(0, 0, 1, WN'(5), WN'(5));
    chk("drop_y_valid",  int'(y_valid),  0);
    chk("drop_yI_hold",  int'(yi),       31);
    chk("drop_yQ_hold",  int'(yq),       331);
    chk("drop_inflight", int'(inflight), 0);
    chk("drop_err",      int'(err),      int'(ERRV));
    // oidx must not have moved: the next frame still keeps exactly 16..31.
    step(1, 0, 0, 0, 0);
    chk("drop_start_inflight", int'(inflight), 1);
    run_frame("after_drop", 1'b0, 2'd0, 1'b1, 3, ERRV);

    do_reset();
    #1;
    chk_reset_vals("sync_rst");

    // ---------------- credit saturation and collision ----------------
    step(1, 0, 0, 0, 0);
    chk("start1_inflight", int'(inflight), 1);
    chk("start1_src_en",   int'(src_en),   1);
    step(1, 0, 0, 0, 0);
    chk("start2_inflight", int'(inflight), 2);
    chk("start2_src_en",   int'(src_en),   0);
    chk("start2_err",      int'(err),      0);
    // Last sample of the frame collides with a new start at inflight=MAXF.
    run_frame("collide", 1'b1, 2'd2, 1'b0, 1, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("overflow_inflight", int'(inflight), 2);
    chk("overflow_src_en",   int'(src_en),   0);
    chk("overflow_err",      int'(err),      int'(ERRV));

    // ---------------- async reset mid-frame (index 20) ----------------
    for (int k = 0; k <= 20; k++)
      step(0, 0, 1, WN'(k), WN'(k + 200));
    chk("pre_rst_y_valid", int'(y_valid), 1);
    chk("pre_rst_yI",      int'(yi),      20);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    fft_start = 1'b0; fft_valid = 1'b0; ifft_valid = 1'b0;
    step(1, 0, 0, 0, 0);
    chk("post_rst_inflight", int'(inflight), 1);
    run_frame("post_rst", 1'b0, 2'd0, 1'b1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
